// File: rtl/pipe_collide_pkg.sv
// Shared constants and state encoding for the flappy dot pipeline.
package flappy_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GAP_MIN = 8;
  localparam int GAP_RESET = 45;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PLAY  = 2'd1,
    HIT   = 2'd2,
    REARM = 2'd3
  } state_e;
endpackage

// File: rtl/pipe_collide_if.sv
// Coordinate-in / status-out bundle between the dot generator, pipe_collide and VGA stage.
interface pipe_collide_if #(
  parameter int NUM_PIPES = 4
);
  logic [7:0]             dot_x_cord;
  logic [6:0]             dot_y_cord;
  logic                   reset_col;
  logic                   collided;
  logic [7:0]             score;
  logic [7:0]             best;
  logic [7*NUM_PIPES-1:0] gap_tops;
  logic                   loading;

  modport master (
    output dot_x_cord, dot_y_cord, reset_col,
    input  collided, score, best, gap_tops, loading
  );

  modport slave (
    input  dot_x_cord, dot_y_cord, reset_col,
    output collided, score, best, gap_tops, loading
  );
endinterface

// File: rtl/pipe_collide_lfsr16.sv
// Free-running 16-bit Galois LFSR, shifting right once per clock.
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] lfsr
);

  // Shift right; fold the polynomial in when a one falls out of bit 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_POLY;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

endmodule

// File: rtl/pipe_collide.sv
// Pipe gap table, dot collision check and pass scoring for the flappy dot game.
// Gaps are redrawn from the LFSR each lap; collided feeds back to the coordinate generator.
module pipe_collide
  import flappy_pkg::*;
#(
  parameter int          NUM_PIPES  = 4,
  parameter int          PIPE_X0    = 32,
  parameter int          PIPE_PITCH = 32,
  parameter int          PIPE_W     = 8,
  parameter int          GAP_H      = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic          dot_clk,
  input  logic          resetn,
  pipe_collide_if.slave bus
);

  localparam int             IDX_W    = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIPES - 1);

  logic [15:0]            lfsr_s;
  logic [9:0]             lfsr_unused_s;
  state_e                 state_r, state_nx_s;
  logic [IDX_W-1:0]       idx_r, idx_nx_s;
  logic [6:0]             gap_top_r [NUM_PIPES];
  logic [6:0]             gap_new_s;
  logic [7*NUM_PIPES-1:0] gaps_s;
  logic [NUM_PIPES-1:0]   passed_r, passed_nx_s, pipe_hit_s, exit_s;
  logic                   hit_s, collided_r, collided_nx_s, loading_r;
  logic [7:0]             score_r, score_nx_s, best_r;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (dot_clk),
    .resetn (resetn),
    .lfsr   (lfsr_s)
  );

  assign lfsr_unused_s = lfsr_s[15:6];
  assign gap_new_s     = 7'(GAP_MIN) + {1'b0, lfsr_s[5:0]};

  // Gap bottom is formed at 8 bits so gap_top + GAP_H never wraps
  for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
    localparam logic [7:0] PX      = 8'(PIPE_X0 + k * PIPE_PITCH);
    localparam logic [7:0] PX_END  = 8'(PIPE_X0 + k * PIPE_PITCH + PIPE_W - 1);
    localparam logic [7:0] PX_EXIT = 8'(PIPE_X0 + k * PIPE_PITCH + PIPE_W);
    logic [7:0] gap_bot_s;
    logic       in_col_s, outside_s;
    assign gap_bot_s     = {1'b0, gap_top_r[k]} + 8'(GAP_H);
    assign in_col_s      = (bus.dot_x_cord >= PX) && (bus.dot_x_cord <= PX_END);
    assign outside_s     = (bus.dot_y_cord < gap_top_r[k]) || ({1'b0, bus.dot_y_cord} >= gap_bot_s);
    assign pipe_hit_s[k] = in_col_s && outside_s;
    assign exit_s[k]     = (bus.dot_x_cord == PX_EXIT) && !passed_r[k];
  end

  assign hit_s = (bus.dot_y_cord == 7'd0) || (bus.dot_y_cord >= 7'(SCREEN_H - 1)) || (|pipe_hit_s);

  // Next-state, pass scoring and collision pulse decode
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    passed_nx_s   = passed_r;
    collided_nx_s = 1'b0;
    score_nx_s    = score_r;
    case (state_r)
      LOAD: begin
        if (!bus.reset_col) begin
          idx_nx_s = '0;
        end else if (idx_r == IDX_LAST) begin
          idx_nx_s   = '0;
          state_nx_s = PLAY;
        end else begin
          idx_nx_s = idx_r + IDX_W'(1);
        end
      end
      PLAY: begin
        if (hit_s) begin
          state_nx_s    = HIT;
          collided_nx_s = 1'b1;
          score_nx_s    = 8'd0;
        end else begin
          if (|exit_s) begin
            passed_nx_s = passed_r | exit_s;
            score_nx_s  = (score_r == 8'd255) ? score_r : score_r + 8'd1;
          end else begin
            passed_nx_s = passed_r;
          end
          if (!bus.reset_col) begin
            state_nx_s  = LOAD;
            idx_nx_s    = '0;
            passed_nx_s = '0;
          end else begin
            state_nx_s = PLAY;
          end
        end
      end
      HIT: begin
        state_nx_s = REARM;
      end
      REARM: begin
        if (!bus.reset_col) begin
          state_nx_s  = LOAD;
          idx_nx_s    = '0;
          passed_nx_s = '0;
        end else begin
          state_nx_s = REARM;
        end
      end
      default: begin
        state_nx_s = LOAD;
        idx_nx_s   = '0;
      end
    endcase
  end

  // State, pass flags and registered status outputs
  always_ff @(posedge dot_clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= LOAD;
      idx_r      <= '0;
      passed_r   <= '0;
      collided_r <= 1'b0;
      score_r    <= 8'd0;
      best_r     <= 8'd0;
      loading_r  <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      passed_r   <= passed_nx_s;
      collided_r <= collided_nx_s;
      score_r    <= score_nx_s;
      loading_r  <= (state_nx_s == LOAD);
      if (score_nx_s > best_r) begin
        best_r <= score_nx_s;
      end
    end
  end

  // Gap table: mid-screen after reset, one pipe rewritten per LOAD cycle
  always_ff @(posedge dot_clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_PIPES; k++) begin
        gap_top_r[k] <= 7'(GAP_RESET);
      end
    end else if (state_r == LOAD) begin
      gap_top_r[idx_r] <= gap_new_s;
    end
  end

  // Flatten the gap table for the drawing stage
  always_comb begin
    gaps_s = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      gaps_s[7*k +: 7] = gap_top_r[k];
    end
  end

  assign bus.collided = collided_r;
  assign bus.score    = score_r;
  assign bus.best     = best_r;
  assign bus.gap_tops = gaps_s;
  assign bus.loading  = loading_r;

endmodule

// File: tb/tb_pipe_collide.sv
// Directed, table-driven bench for pipe_collide: gap loading, collisions, scoring and lap strobes.
module tb_pipe_collide;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_collide_if #(.NUM_PIPES(4)) bus ();

  pipe_collide #(
    .NUM_PIPES  (4),
    .PIPE_X0    (32),
    .PIPE_PITCH (32),
    .PIPE_W     (8),
    .GAP_H      (30),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .dot_clk (clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  // Reference LFSR, used to predict the gaps drawn on later laps
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic [7:0] x;
    int         yrel;
    int         pk;
    int         yv;
    int         rc;
    int         reps;
    int         reload;
    int         ec;
    int         es;
    int         eb;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  int   npass = 0;
  int   ntot = 0;
  int   cur_gap [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot = ntot + 1;
    if (act === exp) npass = npass + 1;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(input int x, input int yrel, input int pk, input int yv, input int rc,
                              input int reps, input int reload, input int ec, input int es,
                              input int eb, input string nm);
    vec_t v;
    v.x = 8'(x); v.yrel = yrel; v.pk = pk; v.yv = yv; v.rc = rc; v.reps = reps;
    v.reload = reload; v.ec = ec; v.es = es; v.eb = eb; v.nm = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    for (int r = 0; r < v.reps; r++) begin
      bus.dot_x_cord = v.x;
      bus.dot_y_cord = (v.yrel != 0) ? 7'(cur_gap[v.pk] + v.yv) : 7'(v.yv);
      bus.reset_col  = (v.rc != 0);
      @(negedge clk);
      chk({v.nm, "_collided"}, {31'd0, bus.collided}, v.ec);
      chk({v.nm, "_score"}, {24'd0, bus.score}, v.es);
      chk({v.nm, "_best"}, {24'd0, bus.best}, v.eb);
      chk({v.nm, "_loading"}, {31'd0, bus.loading}, 0);
    end
  endtask

  // Lap strobe, optional mid-LOAD restart, then four LOAD cycles with predicted gaps
  task automatic reload(input int restart_at);
    int          eg [4];
    logic [27:0] p;
    bus.dot_x_cord = 8'd10;
    bus.dot_y_cord = 7'd60;
    bus.reset_col  = 1'b0;
    @(negedge clk);
    chk("load_enter", {31'd0, bus.loading}, 1);
    bus.reset_col = 1'b1;
    for (int i = 0; i < restart_at; i++) @(negedge clk);
    if (restart_at >= 0) begin
      bus.reset_col = 1'b0;
      @(negedge clk);
      chk("load_restart", {31'd0, bus.loading}, 1);
      bus.reset_col = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      chk("load_cycle", {31'd0, bus.loading}, 1);
      eg[i] = 8 + int'(m_lfsr[5:0]);
      @(negedge clk);
    end
    chk("load_done", {31'd0, bus.loading}, 0);
    chk("load_no_collide", {31'd0, bus.collided}, 0);
    p = '0;
    for (int k = 0; k < 4; k++) p[7*k +: 7] = 7'(eg[k]);
    chk("reload_gap_tops", {4'd0, bus.gap_tops}, {4'd0, p});
    for (int k = 0; k < 4; k++) cur_gap[k] = eg[k];
  endtask

  initial begin
    logic [27:0] gold;
    // x, yrel, pipe, y/offset, reset_col, reps, reload_after, collided, score, best, name
    vecs.push_back(mk( 10, 0, 0,  60, 1,  1, 0, 0, 0, 0, "idle"));
    vecs.push_back(mk( 32, 1, 0,   0, 1,  1, 0, 0, 0, 0, "gap_top_edge"));
    vecs.push_back(mk( 39, 1, 0,  29, 1,  1, 0, 0, 0, 0, "gap_bot_edge"));
    vecs.push_back(mk( 10, 0, 0, 118, 1,  1, 0, 0, 0, 0, "y_118"));
    vecs.push_back(mk( 31, 1, 0,  -1, 1,  1, 0, 0, 0, 0, "x31_outside"));
    vecs.push_back(mk( 40, 1, 0,  15, 1,  1, 0, 0, 1, 1, "pass0"));
    vecs.push_back(mk( 40, 1, 0,  15, 1, 10, 0, 0, 1, 1, "hold_pass0"));
    vecs.push_back(mk( 72, 0, 0,  60, 1,  1, 0, 0, 2, 2, "pass1"));
    vecs.push_back(mk(104, 0, 0,   1, 1,  1, 0, 0, 3, 3, "pass2_y1"));
    vecs.push_back(mk(136, 0, 0, 119, 1,  1, 0, 1, 0, 3, "hit_and_pass"));
    vecs.push_back(mk(136, 0, 0, 119, 1,  1, 0, 0, 0, 3, "pulse_end"));
    vecs.push_back(mk(136, 0, 0, 119, 1,  4, 1, 0, 0, 3, "rearm_hold"));
    vecs.push_back(mk( 40, 1, 0,  15, 1,  1, 0, 0, 1, 3, "repass0"));
    vecs.push_back(mk( 64, 1, 1,  -1, 1,  1, 0, 1, 0, 3, "hit_above_gap"));
    vecs.push_back(mk( 64, 1, 1,  -1, 1,  5, 1, 0, 0, 3, "held_hit"));
    vecs.push_back(mk( 71, 1, 1,  30, 1,  1, 0, 1, 0, 3, "hit_below_gap"));
    vecs.push_back(mk( 71, 1, 1,  30, 1,  2, 1, 0, 0, 3, "below_rearm"));
    vecs.push_back(mk( 10, 0, 0,   0, 1,  1, 0, 1, 0, 3, "y_zero"));
    vecs.push_back(mk( 10, 0, 0,   0, 1,  3, 1, 0, 0, 3, "y_zero_rearm"));
    vecs.push_back(mk( 10, 0, 0, 127, 1,  1, 0, 1, 0, 3, "y_127"));
    vecs.push_back(mk( 10, 0, 0, 127, 1,  3, 1, 0, 0, 3, "y_127_rearm"));
    vecs.push_back(mk( 40, 1, 0,  15, 1,  1, 1, 0, 1, 3, "pass_then_play_strobe"));
    vecs.push_back(mk( 40, 1, 0,  15, 1,  1, 0, 0, 2, 3, "repass_flags_cleared"));
    vecs.push_back(mk( 32, 1, 0,  -1, 0,  1, 0, 1, 0, 3, "hit_beats_strobe"));
    vecs.push_back(mk( 10, 0, 0,  60, 1,  3, 1, 0, 0, 3, "rearm_after_strobe"));

    bus.dot_x_cord = 8'd10;
    bus.dot_y_cord = 7'd0;
    bus.reset_col  = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    gold = {7'd45, 7'd45, 7'd45, 7'd45};
    chk("rst_loading", {31'd0, bus.loading}, 1);
    chk("rst_collided", {31'd0, bus.collided}, 0);
    chk("rst_score", {24'd0, bus.score}, 0);
    chk("rst_best", {24'd0, bus.best}, 0);
    chk("rst_gap_tops", {4'd0, bus.gap_tops}, {4'd0, gold});

    // Boundary y is held during the first load: it must not register as a hit
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("init_loading", {31'd0, bus.loading}, 1);
      chk("init_no_collide", {31'd0, bus.collided}, 0);
      if (i == 3) bus.dot_y_cord = 7'd60;
      @(negedge clk);
    end
    chk("init_loading_off", {31'd0, bus.loading}, 0);
    chk("init_no_collide_play", {31'd0, bus.collided}, 0);
    gold = {7'd36, 7'd64, 7'd56, 7'd41};
    chk("init_gap_tops", {4'd0, bus.gap_tops}, {4'd0, gold});
    cur_gap = '{41, 56, 64, 36};

    foreach (vecs[i]) begin
      apply(vecs[i]);
      if (vecs[i].reload != 0) reload(-1);
    end

    reload(2);
    apply(mk(40, 1, 0, 15, 1, 1, 0, 0, 1, 3, "pass_after_restart"));

    #2 resetn = 1'b0;
    #1;
    chk("async_rst_best", {24'd0, bus.best}, 0);
    chk("async_rst_score", {24'd0, bus.score}, 0);
    chk("async_rst_loading", {31'd0, bus.loading}, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pipe_collide.md
# pipe_collide

Downstream companion of the dot coordinate generator. Holds the vertical gap positions of a fixed row of pipe columns, draws new gaps from an LFSR on every lap, and checks each new dot coordinate against the pipes and the screen edges. It drives `collided` back into the coordinate generator, counts pipes cleared, and exports gap positions to the VGA drawing stage.

## Interface
- `NUM_PIPES`, 4: pipe columns; pipe k left edge at `PIPE_X0 + k*PIPE_PITCH`
- `PIPE_X0`, 32: x of pipe 0 left edge
- `PIPE_PITCH`, 32: x spacing between pipes
- `PIPE_W`, 8: pipe width in pixels
- `GAP_H`, 30: vertical opening height in pixels
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero
- `dot_clk` in 1: the dot update clock, shared with the coordinate generator
- `resetn` in 1: asynchronous, active-low reset
- `dot_x_cord` in 8: dot x, 0..160
- `dot_y_cord` in 7: dot y, 0..127; values above 119 are an underflow or overflow
- `reset_col` in 1: active-low lap strobe from the coordinate generator; low means x wrapped or the dot was reset
- `collided` out 1: one-cycle pulse on a hit
- `score` out 8: pipes cleared since the last hit; saturates at 255
- `best` out 8: highest `score` since reset
- `gap_tops` out 7*NUM_PIPES: gap top y for pipe k in bits [7k+6:7k]
- `loading` out 1: high while gaps are being regenerated

## Operation
- Free-running LFSR: 16-bit Galois, polynomial 0xB400, shifts right every cycle including LOAD.
- New gap value: `GAP_MIN + lfsr[5:0]`, with `GAP_MIN` = 8. Range is 8..71, so the gap bottom is at most 100, inside the 120-line screen.
- State machine, `state` register:
  - LOAD: writes `gap_top[idx]`, then `idx++`. After idx = NUM_PIPES-1 is written, the next state is PLAY. Collision and scoring are disabled.
  - PLAY: evaluates the current coordinates every cycle.
    - Hit: next state HIT. `collided` goes to 1 and `score` goes to 0.
    - Else if `reset_col` = 0: next state LOAD with idx = 0, and all `passed` flags clear.
  - HIT: `collided` goes back to 0 and the next state is REARM.
  - REARM: ignores coordinates. On `reset_col` = 0, next state LOAD with idx = 0 and flags clear.
- A hit is any of the following:
  - `dot_y_cord` = 0.
  - `dot_y_cord` ≥ 119.
  - Some pipe k has `px_k ≤ x ≤ px_k+PIPE_W-1` and either `y < gap_top[k]` or `y ≥ gap_top[k]+GAP_H`.
- Pass: in PLAY with no hit, `x == px_k+PIPE_W` and `passed[k]` = 0. Then `passed[k]` is set and `score` increments, saturating at 255.
  - Multiple pipes cannot pass in the same cycle because pitch > width.
- `best` is set to `score`'s next value whenever that value exceeds `best`.
- Width rules:
  - Compare `gap_top+GAP_H` at 8 bits, so there is no 7-bit overflow.
  - `px_k` is a constant of 8 bits.

## Timing
- Reset (async, `resetn` low): `state`, `idx`, flags and outputs take these values immediately.
  - `state` = LOAD, idx = 0.
  - `lfsr` = LFSR_SEED.
  - All `gap_top` = 45.
  - `passed` = 0.
  - `collided` = 0, `score` = 0, `best` = 0, `loading` = 1.
- Reset release: gaps are regenerated over NUM_PIPES edges, then PLAY.
- Latency: coordinates sampled at edge N produce `collided`/`score` at edge N+1. The coordinate generator acts on `collided` at edge N+2.
- `collided` is high for exactly one cycle per hit. No second pulse until a LOAD completes.
- Hit and pass in the same cycle: the hit wins and `score` becomes 0.
- Hit and `reset_col` = 0 in the same PLAY cycle: the hit wins. The strobe is honoured later from REARM.
- `reset_col` = 0 during LOAD: idx restarts at 0.
- Frozen coordinates (`keep_moving` low upstream): no repeat scoring, because of the `passed` flags. A held hit coordinate yields one pulse, then REARM.
- `loading` = 1 exactly in LOAD.
- `gap_tops` are registered and change only on LOAD writes.

## Structure
- Shared package `flappy_pkg`: SCREEN_W = 160, SCREEN_H = 120, GAP_MIN = 8, GAP_RESET = 45, LFSR_POLY = 16'hB400, and the state encoding LOAD/PLAY/HIT/REARM.
- Sub-module `lfsr16`: clock, resetn, seed parameter, 16-bit state output.
- Pipe x positions come from a generate loop over NUM_PIPES. No RAM.

## Test plan
- Reset with seed 16'hACE1, hold `reset_col`=1 → `loading` is 1 for 4 cycles. Then `gap_tops` match the golden LFSR model and `collided` stays 0.
- Force `gap_top[0]` = 45, drive x=32, y=50 → no hit. Drive x=40 next cycle → `score` = 1 one cycle later. Hold x=40 for 10 cycles → `score` stays 1.
- With `gap_top[1]` = 45, drive x=64, y=44 → `collided`=1 for exactly one cycle and `score`=0. Repeat y=44 for 5 cycles → no further pulse until a `reset_col` low plus LOAD.
- Drive y=0 at x=10, and separately y=127 → a single hit each time.
- Set `score` to 3, drive hit and pass together on adjacent pipes → `score`=0, `best`=3.
- Drive `reset_col`=0 in PLAY → LOAD with new gaps and flags cleared. Repass pipe 0 → `score` increments again. Pulse `reset_col` low mid-LOAD → idx restarts, 4 more LOAD cycles.
